// File: rtl/i2c_transaction_controller.sv
// I2C target-side transaction controller: address/ACK sequencing, write capture, read shifting.
// Optional macro I2C_RX_FLOW_EN: NACK a written byte when the sink is not ready.
module i2c_transaction_controller #(
    parameter int unsigned BYTE_CNT_W = 8
) (
    input  logic                  scl,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sda,
    input  logic                  address_match,
    input  logic                  read_bit,
    input  logic                  write_bit,
    input  logic [7:0]            tx_data,
    input  logic                  rx_ready,
    output logic                  read_address,
    output logic [3:0]            clock_count,
    output logic                  sda_oe,
    output logic                  sda_out,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    output logic                  busy,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            count_nxt;
    logic [7:0]            shift, shift_nxt;
    logic [7:0]            rx_data_nxt;
    logic                  rx_valid_nxt, tx_req_nxt;
    logic [BYTE_CNT_W-1:0] bc_nxt, bc_inc;
    logic                  accept_byte;

`ifdef I2C_RX_FLOW_EN
    assign accept_byte = rx_ready;
`else
    logic unused_rx_ready;
    assign unused_rx_ready = rx_ready;
    assign accept_byte     = 1'b1;
`endif

    assign bc_inc       = (byte_count == '1) ? byte_count : byte_count + BYTE_CNT_W'(1);
    assign read_address = (state == ADDR);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        count_nxt    = clock_count;
        shift_nxt    = shift;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        bc_nxt       = byte_count;
        sda_oe       = 1'b0;
        sda_out      = 1'b1;

        // Pad drive depends on the current state only, so reset releases sda at once
        case (state)
            ADDR_ACK, WR_ACK: begin
                sda_oe  = 1'b1;
                sda_out = 1'b0;
            end
            RD_DATA: begin
                sda_oe  = 1'b1;
                sda_out = shift[3'd7 - clock_count[2:0]];
            end
            default: ;
        endcase

        if (start) begin
            state_nxt = ADDR;
            count_nxt = '0;
            bc_nxt    = '0;
        end else if (stop) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                ADDR: begin
                    if (clock_count == 4'd7) begin
                        state_nxt = address_match ? ADDR_ACK : WAIT_STOP;
                        count_nxt = address_match ? 4'd8 : 4'd0;
                    end else begin
                        count_nxt = clock_count + 4'd1;
                    end
                end
                ADDR_ACK: begin
                    count_nxt = '0;
                    if (write_bit) begin
                        state_nxt = WR_DATA;
                    end else if (read_bit) begin
                        state_nxt  = RD_DATA;
                        shift_nxt  = tx_data;
                        tx_req_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_STOP;
                    end
                end
                WR_DATA: begin
                    shift_nxt = {shift[6:0], sda};
                    if (clock_count == 4'd7) begin
                        if (accept_byte) begin
                            state_nxt    = WR_ACK;
                            count_nxt    = 4'd8;
                            rx_data_nxt  = {shift[6:0], sda};
                            rx_valid_nxt = 1'b1;
                            bc_nxt       = bc_inc;
                        end else begin
                            state_nxt = WAIT_STOP;
                            count_nxt = '0;
                        end
                    end else begin
                        count_nxt = clock_count + 4'd1;
                    end
                end
                WR_ACK: begin
                    state_nxt = WR_DATA;
                    count_nxt = '0;
                end
                RD_DATA: begin
                    if (clock_count == 4'd7) begin
                        state_nxt = RD_ACK;
                        count_nxt = 4'd8;
                    end else begin
                        count_nxt = clock_count + 4'd1;
                    end
                end
                RD_ACK: begin
                    count_nxt = '0;
                    if (!sda) begin
                        state_nxt  = RD_DATA;
                        shift_nxt  = tx_data;
                        tx_req_nxt = 1'b1;
                        bc_nxt     = bc_inc;
                    end else begin
                        state_nxt = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge scl or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clock_count <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            byte_count  <= '0;
        end else begin
            state       <= state_nxt;
            clock_count <= count_nxt;
            shift       <= shift_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            tx_req      <= tx_req_nxt;
            byte_count  <= bc_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_transaction_controller.sv
// Directed self-checking bench for i2c_transaction_controller.
// Honours I2C_RX_FLOW_EN when the build defines it.
module tb_i2c_transaction_controller;

    logic       scl, rst_n, start, stop, sda;
    logic       address_match, read_bit, write_bit, rx_ready;
    logic [7:0] tx_data;
    logic       read_address, sda_oe, sda_out, rx_valid, tx_req, busy;
    logic [3:0] clock_count;
    logic [7:0] rx_data;
    logic [7:0] byte_count;

    int errors = 0;
    int checks = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int both_cnt = 0;

    i2c_transaction_controller #(.BYTE_CNT_W(8)) dut (
        .scl(scl), .rst_n(rst_n), .start(start), .stop(stop), .sda(sda),
        .address_match(address_match), .read_bit(read_bit), .write_bit(write_bit),
        .tx_data(tx_data), .rx_ready(rx_ready), .read_address(read_address),
        .clock_count(clock_count), .sda_oe(sda_oe), .sda_out(sda_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .busy(busy),
        .byte_count(byte_count)
    );

    initial begin
        scl = 1'b0;
        forever #5 scl = ~scl;
    end

    always @(negedge scl) begin
        if (rx_valid) rxv_cnt++;
        if (tx_req) txr_cnt++;
        if (rx_valid && tx_req) both_cnt++;
    end

    task automatic tick;
        @(posedge scl);
        #1;
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rw, input logic match);
        for (int i = 0; i < 8; i++) begin
            sda = (i < 7) ? a[6-i] : rw;
            address_match = (i == 7) ? match : 1'b0;
            tick();
        end
        address_match = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sda = b[7-i];
            tick();
        end
        sda = 1'b1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, read_address, sda_oe, sda_out, rx_valid, tx_req} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000100",
                     {busy, read_address, sda_oe, sda_out, rx_valid, tx_req});
        end
        checks++;
        if ({clock_count, rx_data, byte_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_values: got cnt=%0d rx=%h bc=%0d want 0/00/0",
                     clock_count, rx_data, byte_count);
        end
        start = 1'b0;
        #2 rst_n = 1'b1;
        stop = 1'b1;
        sda = 1'b0;
        address_match = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        sda = 1'b1;
        address_match = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_inputs: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_write;
        int rxv0;
        do_start();
        checks++;
        if ({busy, read_address, clock_count} !== 6'b110000) begin
            errors++;
            $display("FAIL start_to_addr: got busy=%b ra=%b cnt=%0d want 1/1/0",
                     busy, read_address, clock_count);
        end
        send_addr(7'b1100110, 1'b0, 1'b1);
        checks++;
        if ({sda_oe, sda_out, read_address, clock_count} !== 7'b1001000) begin
            errors++;
            $display("FAIL addr_ack: got oe=%b out=%b ra=%b cnt=%0d want 1/0/0/8",
                     sda_oe, sda_out, read_address, clock_count);
        end
        write_bit = 1'b1;
        tick();
        write_bit = 1'b0;
        checks++;
        if ({sda_oe, clock_count} !== 5'b00000) begin
            errors++;
            $display("FAIL wr_entry: got oe=%b cnt=%0d want 0/0", sda_oe, clock_count);
        end
        rxv0 = rxv_cnt;
        send_byte(8'hA5);
        checks++;
        if ({rx_data, rx_valid, byte_count} !== {8'hA5, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL wr_byte: got rx=%h v=%b bc=%0d want a5/1/1", rx_data, rx_valid, byte_count);
        end
        checks++;
        if ({sda_oe, sda_out, clock_count} !== 6'b101000) begin
            errors++;
            $display("FAIL wr_ack: got oe=%b out=%b cnt=%0d want 1/0/8", sda_oe, sda_out, clock_count);
        end
        tick();
        checks++;
        if ({rx_valid, sda_oe, clock_count, busy} !== 7'b0000001) begin
            errors++;
            $display("FAIL wr_return: got v=%b oe=%b cnt=%0d busy=%b want 0/0/0/1",
                     rx_valid, sda_oe, clock_count, busy);
        end
        checks++;
        if (rxv_cnt - rxv0 !== 1) begin
            errors++;
            $display("FAIL wr_rxv_pulses: got %0d want 1", rxv_cnt - rxv0);
        end
    endtask

    task automatic test_back_to_back;
        send_byte(8'h3C);
        checks++;
        if ({rx_data, byte_count} !== {8'h3C, 8'd2}) begin
            errors++;
            $display("FAIL b2b_second: got rx=%h bc=%0d want 3c/2", rx_data, byte_count);
        end
        tick();
        sda = 1'b0; tick();
        sda = 1'b1; tick();
        start = 1'b1;
        tick();
        checks++;
        if ({read_address, clock_count, byte_count} !== 13'b1_0000_00000000) begin
            errors++;
            $display("FAIL rep_start: got ra=%b cnt=%0d bc=%0d want 1/0/0",
                     read_address, clock_count, byte_count);
        end
        sda = 1'b0; start = 1'b0; tick(); tick();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({read_address, clock_count} !== 5'b10000) begin
            errors++;
            $display("FAIL start_beats_stop: got ra=%b cnt=%0d want 1/0", read_address, clock_count);
        end
        tick();
        stop = 1'b0;
        sda = 1'b1;
        checks++;
        if ({busy, sda_oe} !== 2'b00) begin
            errors++;
            $display("FAIL stop_idle: got busy=%b oe=%b want 0/0", busy, sda_oe);
        end
    endtask

    task automatic test_nomatch;
        int oe_hits = 0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            sda = i[0];
            tick();
            if (sda_oe) oe_hits++;
        end
        for (int i = 0; i < 4; i++) begin
            sda = ~i[0];
            tick();
            if (sda_oe) oe_hits++;
        end
        sda = 1'b1;
        checks++;
        if ({busy, read_address} !== 2'b10) begin
            errors++;
            $display("FAIL nomatch_wait: got busy=%b ra=%b want 1/0", busy, read_address);
        end
        checks++;
        if (oe_hits !== 0) begin
            errors++;
            $display("FAIL nomatch_oe: got %0d drive cycles want 0", oe_hits);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_stop: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_read;
        int txr0;
        logic [7:0] got;
        int oe_bad = 0;
        do_start();
        send_addr(7'b1100110, 1'b1, 1'b1);
        txr0 = txr_cnt;
        read_bit = 1'b1;
        tx_data = 8'h3C;
        tick();
        read_bit = 1'b0;
        tx_data = 8'hF0;
        checks++;
        if ({tx_req, sda_oe, clock_count} !== 6'b110000) begin
            errors++;
            $display("FAIL rd_entry: got req=%b oe=%b cnt=%0d want 1/1/0", tx_req, sda_oe, clock_count);
        end
        for (int i = 0; i < 8; i++) begin
            got[7-i] = sda_out;
            if (!sda_oe) oe_bad++;
            tick();
        end
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL rd_byte0: got %b want 00111100", got);
        end
        checks++;
        if ({sda_oe, clock_count} !== 5'b01000) begin
            errors++;
            $display("FAIL rd_ack_release: got oe=%b cnt=%0d want 0/8", sda_oe, clock_count);
        end
        sda = 1'b0;
        tick();
        sda = 1'b1;
        checks++;
        if ({tx_req, byte_count} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL rd_master_ack: got req=%b bc=%0d want 1/1", tx_req, byte_count);
        end
        for (int i = 0; i < 8; i++) begin
            got[7-i] = sda_out;
            if (!sda_oe) oe_bad++;
            tick();
        end
        checks++;
        if (got !== 8'hF0) begin
            errors++;
            $display("FAIL rd_byte1: got %b want 11110000", got);
        end
        checks++;
        if (oe_bad !== 0) begin
            errors++;
            $display("FAIL rd_drive: got %0d undriven bit cycles want 0", oe_bad);
        end
        tick();
        checks++;
        if ({busy, read_address, sda_oe, byte_count} !== {3'b100, 8'd1}) begin
            errors++;
            $display("FAIL rd_nack_wait: got busy=%b ra=%b oe=%b bc=%0d want 1/0/0/1",
                     busy, read_address, sda_oe, byte_count);
        end
        tick();
        checks++;
        if (txr_cnt - txr0 !== 2) begin
            errors++;
            $display("FAIL rd_txreq_pulses: got %0d want 2", txr_cnt - txr0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({busy, byte_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL stop_holds_count: got busy=%b bc=%0d want 0/1", busy, byte_count);
        end
    endtask

    task automatic test_async_reset;
        do_start();
        send_addr(7'b1100110, 1'b1, 1'b1);
        read_bit = 1'b1;
        tx_data = 8'hEF;
        tick();
        read_bit = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({clock_count, sda_oe, sda_out} !== 6'b001110) begin
            errors++;
            $display("FAIL rd_count3: got cnt=%0d oe=%b out=%b want 3/1/0", clock_count, sda_oe, sda_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_oe, sda_out, busy, read_address, rx_valid, tx_req} !== 6'b010000) begin
            errors++;
            $display("FAIL async_reset_flags: got %b want 010000",
                     {sda_oe, sda_out, busy, read_address, rx_valid, tx_req});
        end
        checks++;
        if ({clock_count, rx_data, byte_count} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset_values: got cnt=%0d rx=%h bc=%0d want 0/00/0",
                     clock_count, rx_data, byte_count);
        end
        tick();
        rst_n = 1'b1;
        sda = 1'b0;
        tick(); tick();
        sda = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_rx_flow;
        int rxv0;
        do_start();
        send_addr(7'b1100110, 1'b0, 1'b1);
        write_bit = 1'b1;
        tick();
        write_bit = 1'b0;
        rx_ready = 1'b1;
        send_byte(8'h11);
        tick();
        rx_ready = 1'b0;
        rxv0 = rxv_cnt;
        send_byte(8'h22);
`ifdef I2C_RX_FLOW_EN
        checks++;
        if ({rx_valid, sda_oe, busy, rx_data, byte_count} !== {3'b001, 8'h11, 8'd1}) begin
            errors++;
            $display("FAIL flow_nack: got v=%b oe=%b busy=%b rx=%h bc=%0d want 0/0/1/11/1",
                     rx_valid, sda_oe, busy, rx_data, byte_count);
        end
        tick();
        checks++;
        if ({busy, sda_oe, rxv_cnt - rxv0} !== {2'b10, 32'd0}) begin
            errors++;
            $display("FAIL flow_wait: got busy=%b oe=%b pulses=%0d want 1/0/0",
                     busy, sda_oe, rxv_cnt - rxv0);
        end
`else
        checks++;
        if ({rx_valid, sda_oe, sda_out, rx_data, byte_count} !== {3'b110, 8'h22, 8'd2}) begin
            errors++;
            $display("FAIL noflow_ack: got v=%b oe=%b out=%b rx=%h bc=%0d want 1/1/0/22/2",
                     rx_valid, sda_oe, sda_out, rx_data, byte_count);
        end
        tick();
`endif
        rx_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_saturation;
        do_start();
        send_addr(7'b1100110, 1'b0, 1'b1);
        write_bit = 1'b1;
        tick();
        write_bit = 1'b0;
        for (int n = 0; n < 256; n++) begin
            send_byte(n[7:0]);
            if (n == 254) begin
                checks++;
                if (byte_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: got bc=%0d want 255", byte_count);
                end
            end
            tick();
        end
        checks++;
        if ({byte_count, rx_data} !== {8'd255, 8'hFF}) begin
            errors++;
            $display("FAIL sat_hold: got bc=%0d rx=%h want 255/ff", byte_count, rx_data);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sda = 1'b1;
        address_match = 1'b0; read_bit = 1'b0; write_bit = 1'b0;
        tx_data = 8'h00; rx_ready = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_nomatch();
        test_read();
        test_async_reset();
        test_rx_flow();
        test_saturation();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d cycles with rx_valid and tx_req want 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
